// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the instruction/data memory port arbiter
// FSM states, owner codes and a counter-width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between fetch and data requests
// ARB_RR_EN selects round-robin; otherwise data priority with a fetch starvation guard.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
`ifdef ARB_RR_EN
  input  arb_owner_e rr_pri,
`else
  input  logic       starve_full,
`endif
  output logic       grant_valid,
  output arb_owner_e grant
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant       = OWN_D;
`ifdef ARB_RR_EN
    if (i_req && d_req) begin
      grant = rr_pri;
    end else if (i_req) begin
      grant = OWN_I;
    end
`else
    // Data is the older instruction, so it wins unless fetch has waited too long.
    if (i_req && (!d_req || starve_full)) begin
      grant = OWN_I;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between fetch and data ports
// Optional ARB_RR_EN replaces data priority and starvation counting with round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int LAT_W = cnt_width(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  arb_owner_e        grant;
  logic              grant_valid;
  logic              we_q;
  logic [LAT_W-1:0]  lat_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              i_done_q;
  logic              d_done_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_d;
  logic [31:0]       mem_wdata_d;

`ifdef ARB_RR_EN
  arb_owner_e rr_q;
  arb_owner_e rr_d;
`else
  localparam int STV_W = cnt_width(STARVE_MAX);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);
  logic [STV_W-1:0] starve_q;
  logic [STV_W-1:0] starve_d;
`endif

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
`ifdef ARB_RR_EN
    .rr_pri      (rr_q),
`else
    .starve_full (starve_q == STV_MAX),
`endif
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    mem_addr_d  = (grant == OWN_D) ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
    mem_we_d    = (grant == OWN_D) && d_we;
    mem_wdata_d = (grant == OWN_D) ? d_wdata : '0;
`ifdef ARB_RR_EN
    rr_d = (grant == OWN_D) ? OWN_I : OWN_D;
`else
    starve_d = '0;
    if (grant == OWN_D && i_req) begin
      starve_d = (starve_q == STV_MAX) ? starve_q : starve_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      we_q        <= 1'b0;
      lat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_RR_EN
      rr_q        <= OWN_D;
`else
      starve_q    <= '0;
`endif
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q     <= grant;
            we_q        <= mem_we_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef ARB_RR_EN
            rr_q        <= rr_d;
`else
            starve_q    <= starve_d;
`endif
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // Strobe cycle loads the counter; read data is sampled when it reaches zero.
          if (mem_en_q) begin
            lat_q <= LAT_LOAD;
          end else if (lat_q == '0) begin
            state_q <= DONE;
            if (owner_q == OWN_D) begin
              d_done_q  <= 1'b1;
              d_rdata_q <= we_q ? '0 : mem_rdata;
            end else begin
              i_done_q  <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

  assign cpu_stall = ~reset & ((i_req & ~i_done_q) | (d_req & ~d_done_q));
  assign i_done    = i_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Directed scenarios followed by random traffic against a schedule-level reference model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int ADDR_W     = 6;
  localparam int STARVE_MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        cpu_stall;
  logic        mem_en;
  logic        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .cpu_stall (cpu_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] seed_word(input int a);
    logic [31:0] v;
    v = 32'(a);
    return (a == 2) ? 32'hE3A00005 : (32'h5A000000 ^ (v * 32'h00010203));
  endfunction

  // Memory macro: reads return random junk except exactly MEM_LAT cycles after mem_en.
  logic        mem_init;
  logic [31:0] phys [64];
  logic [31:0] pipe [MEM_LAT];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 64; a++) phys[a] <= seed_word(a);
    end else if (mem_en && mem_we) begin
      phys[mem_addr] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? phys[mem_addr] : $urandom;
    for (int s = 1; s < MEM_LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit          m_valid = 1'b0;
  int          exp_en = -1;
  int          exp_done = -1;
  int          free_cyc = 0;
  bit          exp_d;
  bit          exp_we;
  logic [5:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_rdata;
  int          starve = 0;
  bit          rr_d = 1'b1;
  logic [31:0] ref_mem [64];
  string       obs_grants;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit done_i_now();
    return m_valid && (cyc == exp_done) && !exp_d;
  endfunction

  function automatic bit done_d_now();
    return m_valid && (cyc == exp_done) && exp_d;
  endfunction

  // Inputs for the current cycle are already applied; check outputs, advance the model, step.
  task automatic clk_cycle();
    bit          win_d;
    bit          ed_i;
    bit          ed_d;
    logic [31:0] a;
    #1;
    if (reset) begin
      chk1("stall_in_reset", cpu_stall, 1'b0);
      m_valid  = 1'b1;
      exp_en   = -1;
      exp_done = -1;
      free_cyc = cyc + 1;
      starve   = 0;
      rr_d     = 1'b1;
    end else if (m_valid) begin
      ed_i = done_i_now();
      ed_d = done_d_now();
      chk1("mem_en", mem_en, cyc == exp_en);
      if (cyc == exp_en) begin
        chk32("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk1("mem_we", mem_we, exp_we);
        if (exp_we) chk32("mem_wdata", mem_wdata, exp_wdata);
      end else begin
        chk1("mem_we_idle", mem_we, 1'b0);
      end
      chk1("i_done", i_done, ed_i);
      chk1("d_done", d_done, ed_d);
      if (ed_i) chk32("i_rdata", i_rdata, exp_rdata);
      if (ed_d) chk32("d_rdata", d_rdata, exp_rdata);
      chk1("cpu_stall", cpu_stall, (i_req && !ed_i) || (d_req && !ed_d));
      if (mem_en) begin
        if (d_req && (mem_addr == 6'((d_addr / 4) % 64))) obs_grants = {obs_grants, "D"};
        else obs_grants = {obs_grants, "I"};
      end
      if (cyc >= free_cyc && (i_req || d_req)) begin
`ifdef ARB_RR_EN
        win_d = d_req && (!i_req || rr_d);
        rr_d  = !win_d;
`else
        win_d  = d_req && !(i_req && starve == STARVE_MAX);
        starve = (win_d && i_req) ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
`endif
        a         = win_d ? d_addr : i_addr;
        exp_addr  = 6'((a / 4) % 64);
        exp_d     = win_d;
        exp_we    = win_d && d_we;
        exp_wdata = d_wdata;
        exp_rdata = exp_we ? 32'h0 : ref_mem[exp_addr];
        if (exp_we) ref_mem[exp_addr] = d_wdata;
        exp_en    = cyc + 1;
        exp_done  = cyc + MEM_LAT + 2;
        free_cyc  = cyc + MEM_LAT + 3;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0;
    d_req = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < n; k++) clk_cycle();
  endtask

  string exp_order;
  int    en_count;

  initial begin
    for (int a = 0; a < 64; a++) ref_mem[a] = seed_word(a);
    reset = 1'b1; mem_init = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    clk_cycle();
    clk_cycle();
    mem_init = 1'b0;
    reset    = 1'b0;
    #1;
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_i_done", i_done, 1'b0);
    chk32("rst_mem_addr", 32'(mem_addr), 32'h0);
    idle(2);

    // Single fetch: strobe at 1, done at 4.
    for (int t = 0; t < 6; t++) begin
      i_req = (t < 4); i_addr = 32'h08;
      #1;
      if (t == 1) begin
        chk1("t1_en", mem_en, 1'b1);
        chk32("t1_addr", 32'(mem_addr), 32'd2);
        chk1("t1_we", mem_we, 1'b0);
      end
      if (t == 4) begin
        chk1("t1_done", i_done, 1'b1);
        chk32("t1_rdata", i_rdata, 32'hE3A00005);
      end
      clk_cycle();
    end
    idle(2);

    // Contention: data first, fetch follows after MEM_LAT+3 cycles.
    for (int t = 0; t < 11; t++) begin
      i_req = (t < 10); i_addr = 32'h20;
      d_req = (t < 4); d_we = 1'b0; d_addr = 32'h10;
      #1;
      if (t == 1) chk32("t2_daddr", 32'(mem_addr), 32'd4);
      if (t == 4) chk1("t2_ddone", d_done, 1'b1);
      if (t == 5) chk1("t2_stall", cpu_stall, 1'b1);
      if (t == 6) begin
        chk1("t2_ien", mem_en, 1'b1);
        chk32("t2_iaddr", 32'(mem_addr), 32'd8);
      end
      if (t == 9) begin
        chk1("t2_idone", i_done, 1'b1);
        chk1("t2_nostall", cpu_stall, 1'b0);
      end
      clk_cycle();
    end
    idle(2);

    // Write: single strobe, zero read data.
    for (int t = 0; t < 6; t++) begin
      d_req = (t < 4); d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'h7;
      #1;
      if (t == 1) begin
        chk1("t3_en", mem_en, 1'b1);
        chk1("t3_we", mem_we, 1'b1);
        chk32("t3_addr", 32'(mem_addr), 32'd5);
        chk32("t3_wdata", mem_wdata, 32'd7);
      end
      if (t == 2) begin
        chk1("t3_en_off", mem_en, 1'b0);
        chk1("t3_we_off", mem_we, 1'b0);
      end
      if (t == 4) begin
        chk1("t3_done", d_done, 1'b1);
        chk32("t3_rdata", d_rdata, 32'h0);
      end
      clk_cycle();
    end
    d_we = 1'b0;
    idle(2);

    // Sustained contention grant order.
    reset = 1'b1;
    clk_cycle();
    reset = 1'b0;
    obs_grants = "";
    for (int t = 0; t < 30; t++) begin
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      clk_cycle();
    end
`ifdef ARB_RR_EN
    exp_order = "DIDIDI";
`else
    exp_order = "DDIDDI";
`endif
    n_checks++;
    assert (obs_grants == exp_order) else begin
      n_fail++;
      $error("FAIL grant_order: observed %s expected %s", obs_grants, exp_order);
    end
    idle(2);

    // Reset during WAIT abandons the fetch; a fresh data access follows.
    for (int t = 0; t < 14; t++) begin
      i_req = (t < 12); i_addr = 32'h24;
      d_req = (t >= 1) && (t < 7); d_we = 1'b0; d_addr = 32'h2C;
      reset = (t == 2);
      #1;
      if (t == 2) chk1("t5_stall_rst", cpu_stall, 1'b0);
      if (t == 3) begin
        chk1("t5_en", mem_en, 1'b0);
        chk1("t5_we", mem_we, 1'b0);
        chk32("t5_addr", 32'(mem_addr), 32'h0);
        chk32("t5_wdata", mem_wdata, 32'h0);
        chk1("t5_idone", i_done, 1'b0);
        chk1("t5_ddone", d_done, 1'b0);
        chk32("t5_irdata", i_rdata, 32'h0);
        chk32("t5_drdata", d_rdata, 32'h0);
      end
      if (t == 4) begin
        chk1("t5_fresh_en", mem_en, 1'b1);
        chk32("t5_fresh_addr", 32'(mem_addr), 32'd11);
        chk1("t5_no_stale", i_done, 1'b0);
      end
      if (t == 7) chk1("t5_ddone_late", d_done, 1'b1);
      if (t == 12) begin
        chk1("t5_idone_late", i_done, 1'b1);
        chk32("t5_irdata_late", i_rdata, seed_word(9));
      end
      clk_cycle();
    end
    idle(2);

    // Data request dropped mid-access still completes, no re-issue.
    en_count = 0;
    for (int t = 0; t < 15; t++) begin
      d_req = (t < 2); d_we = 1'b0; d_addr = 32'h30;
      #1;
      if (t >= 2 && mem_en) en_count++;
      if (t == 4) begin
        chk1("t6_done", d_done, 1'b1);
        chk32("t6_rdata", d_rdata, seed_word(12));
      end
      clk_cycle();
    end
    chk32("t6_no_reissue", 32'(en_count), 32'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (i_req && done_i_now()) begin
        i_req = ($urandom % 2 == 0);
        i_addr = $urandom;
      end else if (!i_req && ($urandom % 4 == 0)) begin
        i_req = 1'b1;
        i_addr = $urandom;
      end
      if (d_req && done_d_now()) begin
        d_req = ($urandom % 2 == 0);
        d_we = $urandom % 2 == 0;
        d_addr = $urandom;
        d_wdata = $urandom;
      end else if (!d_req && ($urandom % 4 == 0)) begin
        d_req = 1'b1;
        d_we = $urandom % 2 == 0;
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      reset = ($urandom % 64 == 0);
      clk_cycle();
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
